// File: rtl/count_compare_unit_pkg.sv
// rtl/count_compare_unit_pkg.sv - shared widths and FSM state encoding for count_compare_unit
package count_compare_unit_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int EXT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

endpackage

// File: rtl/count_compare_unit_sync_filter.sv
// rtl/count_compare_unit_sync_filter.sv - two-stage sampler accepting a counter value after two equal samples
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   i_cnt_in   raw, possibly settling, upstream counter value
//   o_cur_cnt  last accepted counter value
//   o_upd      accepted value changes on the next edge
//   o_wrap     the pending update is a decrease (low-field wrap)
module count_compare_unit_sync_filter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_cnt_in,
    output logic [CNT_W-1:0] o_cur_cnt,
    output logic             o_upd,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_s1;
    logic [CNT_W-1:0] r_s0;
    logic [CNT_W-1:0] r_cur;
    logic             w_upd;

    // Two equal consecutive samples mean the ripple counter has settled.
    assign w_upd = (r_s1 == r_s0) && (r_s0 != r_cur);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1  <= '0;
            r_s0  <= '0;
            r_cur <= '0;
        end else begin
            r_s1 <= i_cnt_in;
            r_s0 <= r_s1;
            if (w_upd) begin
                r_cur <= r_s0;
            end
        end
    end

    assign o_cur_cnt = r_cur;
    assign o_upd     = w_upd;
    // Any decrease counts as a single wrap; skipped values are not reconstructed.
    assign o_wrap    = w_upd && (r_s0 < r_cur);

endmodule

// File: rtl/count_compare_unit.sv
// rtl/count_compare_unit.sv - extends a settled counter with a wrap counter and raises a held compare interrupt
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   cnt_in      raw upstream counter value
//   cmp_val     compare target, latched when arming
//   arm         arm the compare (honoured in IDLE only)
//   disarm      abort compare / clear interrupt, back to IDLE
//   irq_ack     acknowledge the held interrupt
//   ovf_clr     clear sticky overflow flag
//   count_out   {ext_cnt, cur_cnt}
//   wrap_pulse  one-cycle pulse on an accepted low-field wrap
//   irq         compare match, held until acknowledged
//   armed       FSM is in ARMED
//   ovf         sticky upper-counter overflow
module count_compare_unit
    import count_compare_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EXT_W = EXT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic [EXT_W+CNT_W-1:0] cmp_val,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic                   irq_ack,
    input  logic                   ovf_clr,
    output logic [EXT_W+CNT_W-1:0] count_out,
    output logic                   wrap_pulse,
    output logic                   irq,
    output logic                   armed,
    output logic                   ovf
);

    logic [CNT_W-1:0]       w_cur_cnt;
    logic                   w_upd;
    logic                   w_wrap;
    logic                   w_do_wrap;
    logic [EXT_W+CNT_W-1:0] w_count;
    state_t                 w_state_nxt;
    logic                   w_load_cmp;

    logic [EXT_W-1:0]       r_ext_cnt;
    logic                   r_ovf;
    logic                   r_wrap_pulse;
    logic [EXT_W+CNT_W-1:0] r_cmp_reg;
    state_t                 r_state;
    logic                   r_irq;
    logic                   r_armed;

    count_compare_unit_sync_filter #(
        .CNT_W (CNT_W)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .i_cnt_in  (cnt_in),
        .o_cur_cnt (w_cur_cnt),
        .o_upd     (w_upd),
        .o_wrap    (w_wrap)
    );

    assign w_do_wrap = w_upd && w_wrap;
    assign w_count   = {r_ext_cnt, w_cur_cnt};

    always_comb begin
        w_state_nxt = r_state;
        w_load_cmp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (arm && !disarm) begin
                    w_state_nxt = ARMED;
                    w_load_cmp  = 1'b1;
                end
            end
            ARMED: begin
                if (disarm) begin
                    w_state_nxt = IDLE;
                end else if (w_count == r_cmp_reg) begin
                    w_state_nxt = FIRED;
                end
            end
            FIRED: begin
                if (irq_ack || disarm) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_irq        <= 1'b0;
            r_armed      <= 1'b0;
            r_cmp_reg    <= '0;
            r_ext_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Flags follow the next state so they are registered and line up with r_state.
            r_irq   <= (w_state_nxt == FIRED);
            r_armed <= (w_state_nxt == ARMED);
            if (w_load_cmp) begin
                r_cmp_reg <= cmp_val;
            end
            if (w_do_wrap) begin
                r_ext_cnt <= r_ext_cnt + 1'b1;
            end
            r_wrap_pulse <= w_do_wrap;
            // Setting on overflow takes priority over a same-cycle clear.
            if (w_do_wrap && (&r_ext_cnt)) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count_out  = w_count;
    assign wrap_pulse = r_wrap_pulse;
    assign irq        = r_irq;
    assign armed      = r_armed;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_count_compare_unit.sv
// tb/tb_count_compare_unit.sv - self-checking bench for count_compare_unit
module tb_count_compare_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  cnt_in;
    logic [11:0] cmp_val;
    logic        arm;
    logic        disarm;
    logic        irq_ack;
    logic        ovf_clr;
    logic [11:0] count_out;
    logic        wrap_pulse;
    logic        irq;
    logic        armed;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  cnt;
        logic [11:0] exp_count;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[17];

    count_compare_unit #(
        .CNT_W (4),
        .EXT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .cmp_val    (cmp_val),
        .arm        (arm),
        .disarm     (disarm),
        .irq_ack    (irq_ack),
        .ovf_clr    (ovf_clr),
        .count_out  (count_out),
        .wrap_pulse (wrap_pulse),
        .irq        (irq),
        .armed      (armed),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] v);
        cnt_in = v;
        repeat (3) step();
    endtask

    initial begin
        vecs[0]  = '{4'd1,  12'h001, 1'b0};
        vecs[1]  = '{4'd2,  12'h002, 1'b0};
        vecs[2]  = '{4'd3,  12'h003, 1'b0};
        vecs[3]  = '{4'd4,  12'h004, 1'b0};
        vecs[4]  = '{4'd5,  12'h005, 1'b0};
        vecs[5]  = '{4'd6,  12'h006, 1'b0};
        vecs[6]  = '{4'd7,  12'h007, 1'b0};
        vecs[7]  = '{4'd8,  12'h008, 1'b0};
        vecs[8]  = '{4'd9,  12'h009, 1'b0};
        vecs[9]  = '{4'd10, 12'h00A, 1'b0};
        vecs[10] = '{4'd11, 12'h00B, 1'b0};
        vecs[11] = '{4'd12, 12'h00C, 1'b0};
        vecs[12] = '{4'd13, 12'h00D, 1'b0};
        vecs[13] = '{4'd14, 12'h00E, 1'b0};
        vecs[14] = '{4'd15, 12'h00F, 1'b0};
        vecs[15] = '{4'd0,  12'h010, 1'b1};
        vecs[16] = '{4'd3,  12'h013, 1'b0};

        // 1. reset with random inputs
        rst     = 1'b0;
        cnt_in  = 4'($urandom);
        cmp_val = 12'($urandom);
        arm     = 1'($urandom);
        disarm  = 1'($urandom);
        irq_ack = 1'($urandom);
        ovf_clr = 1'($urandom);
        step();
        cnt_in  = 4'($urandom);
        arm     = 1'b1;
        step();
        chk("rst_count", 32'(count_out), 32'h0);
        chk("rst_wrap", 32'(wrap_pulse), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        cnt_in = 4'd0; cmp_val = 12'h0; arm = 1'b0; disarm = 1'b0;
        irq_ack = 1'b0; ovf_clr = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("rel_count", 32'(count_out), 32'h0);
        chk("rel_armed", 32'(armed), 32'h0);

        // 2. stepping, 3-edge latency, wrap at 15->0
        for (int i = 0; i < 17; i++) begin
            logic [11:0] prev;
            prev = (i == 0) ? 12'h000 : vecs[i-1].exp_count;
            cnt_in = vecs[i].cnt;
            step();
            step();
            chk($sformatf("lat_hold_%0d", i), 32'(count_out), 32'(prev));
            chk($sformatf("lat_wrap0_%0d", i), 32'(wrap_pulse), 32'h0);
            step();
            chk($sformatf("vec_count_%0d", i), 32'(count_out), 32'(vecs[i].exp_count));
            chk($sformatf("vec_wrap_%0d", i), 32'(wrap_pulse), 32'(vecs[i].exp_wrap));
        end

        // 3. unsettled input never accepted
        for (int i = 0; i < 10; i++) begin
            cnt_in = (i % 2 == 0) ? 4'd5 : 4'd6;
            step();
            chk($sformatf("toggle_count_%0d", i), 32'(count_out), 32'h013);
            chk($sformatf("toggle_wrap_%0d", i), 32'(wrap_pulse), 32'h0);
        end
        hold(4'd3);
        chk("toggle_settle", 32'(count_out), 32'h013);

        // 4. compare 0x023, held irq, ack
        cmp_val = 12'h023; arm = 1'b1;
        step();
        arm = 1'b0; cmp_val = 12'h000;
        chk("arm_armed", 32'(armed), 32'h1);
        for (int v = 4; v < 16; v++) begin
            hold(4'(v));
            chk($sformatf("pre_irq_%0d", v), 32'(irq), 32'h0);
        end
        hold(4'd0);
        chk("cmp_wrap_count", 32'(count_out), 32'h020);
        hold(4'd1);
        hold(4'd2);
        chk("pre_irq_2", 32'(irq), 32'h0);
        hold(4'd3);
        chk("match_count", 32'(count_out), 32'h023);
        chk("match_irq0", 32'(irq), 32'h0);
        chk("match_armed", 32'(armed), 32'h1);
        step();
        chk("fired_irq", 32'(irq), 32'h1);
        chk("fired_armed", 32'(armed), 32'h0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        chk("fired_held", 32'(irq), 32'h1);
        chk("fired_arm_ign", 32'(armed), 32'h0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ack_irq", 32'(irq), 32'h0);
        chk("ack_armed", 32'(armed), 32'h0);

        // 5. upper counter overflow; set beats simultaneous clear
        for (int k = 0; k < 253; k++) begin
            hold(4'd8);
            hold(4'd0);
        end
        chk("ext_ff_count", 32'(count_out), 32'hFF0);
        chk("ext_ff_ovf", 32'(ovf), 32'h0);
        hold(4'd8);
        cnt_in = 4'd0;
        step();
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_count", 32'(count_out), 32'h000);
        chk("ovf_wrap", 32'(wrap_pulse), 32'h1);
        chk("ovf_set_wins", 32'(ovf), 32'h1);
        step();
        chk("ovf_sticky", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'h0);

        // 6. disarm, immediate fire, reset while FIRED
        cmp_val = 12'hABC; arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm2_armed", 32'(armed), 32'h1);
        arm = 1'b1; disarm = 1'b1;
        step();
        arm = 1'b0; disarm = 1'b0;
        chk("disarm_armed", 32'(armed), 32'h0);
        chk("disarm_irq", 32'(irq), 32'h0);
        hold(4'd8);
        chk("pre6_count", 32'(count_out), 32'h008);
        cmp_val = 12'h008; arm = 1'b1;
        step();
        arm = 1'b0;
        chk("imm_armed", 32'(armed), 32'h1);
        chk("imm_irq0", 32'(irq), 32'h0);
        step();
        chk("imm_irq", 32'(irq), 32'h1);
        rst = 1'b0;
        cnt_in = 4'($urandom);
        irq_ack = 1'b0;
        step();
        chk("rst_fired_irq", 32'(irq), 32'h0);
        chk("rst_fired_count", 32'(count_out), 32'h000);
        chk("rst_fired_armed", 32'(armed), 32'h0);
        rst = 1'b1;
        cnt_in = 4'd0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
